// File: rtl/ccl_union_labeler.sv
// ccl_fifo: small generic FIFO accepting up to two writes and one read per cycle.
// Latency: a written entry is visible on rd_dat the cycle after the write.
// Backpressure: none internally; the writer must check free_cnt before pushing.
module ccl_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr0_vld,
    input  logic [WIDTH-1:0]           wr0_dat,
    input  logic                       wr1_vld,
    input  logic [WIDTH-1:0]           wr1_dat,
    output logic                       rd_vld,
    input  logic                       rd_rdy,
    output logic [WIDTH-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0]     free_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    wr1_addr;
    logic [1:0]       n_wr;
    logic             pop;

    always_comb begin
        n_wr     = {1'b0, wr0_vld} + {1'b0, wr1_vld};
        pop      = rd_rdy && (cnt_q != '0);
        wr1_addr = wr0_vld ? wr_ptr_q + AW'(1) : wr_ptr_q;
        wr_ptr_d = wr_ptr_q + AW'(n_wr);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d    = cnt_q + CW'(n_wr) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr0_vld) mem_q[wr_ptr_q] <= wr0_dat;
        if (wr1_vld) mem_q[wr1_addr] <= wr1_dat;
    end

    assign rd_vld   = (cnt_q != '0);
    assign rd_dat   = mem_q[rd_ptr_q];
    assign free_cnt = DEPTH_C - cnt_q;
endmodule

// ccl_union_labeler: first-pass CCL labeler with union-find merge resolution and end-of-frame flatten.
// Latency: q/q_valid one cycle after accept; lut_data one cycle after lut_addr.
// Backpressure: in_ready drops when merge FIFO has <2 free slots or outside RUN (drain/flatten/done).
module ccl_union_labeler #(
    parameter int LABEL_W    = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CONN8      = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic               p,
    input  logic [LABEL_W-1:0] A,
    input  logic [LABEL_W-1:0] B,
    input  logic [LABEL_W-1:0] C,
    input  logic [LABEL_W-1:0] D,
    output logic [LABEL_W-1:0] q,
    output logic               q_valid,
    output logic               frame_done,
    output logic [LABEL_W-1:0] label_count,
    output logic               overflow,
    input  logic [LABEL_W-1:0] lut_addr,
    output logic [LABEL_W-1:0] lut_data
);
    localparam int MAXL = 2**LABEL_W - 1;
    localparam logic [LABEL_W-1:0] MAXL_L = '1;
    localparam logic [LABEL_W-1:0] ONE_L  = LABEL_W'(1);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [LABEL_W-1:0] x;
        logic [LABEL_W-1:0] m;
    } merge_t;

    typedef enum logic [1:0] {F_RUN, F_DRAIN, F_FLATTEN, F_DONE} frame_st_t;
    typedef enum logic [1:0] {U_IDLE, U_FIND_X, U_FIND_M, U_LINK} union_st_t;

    frame_st_t          frame_st_q, frame_st_d;
    union_st_t          union_st_q, union_st_d;
    logic [LABEL_W-1:0] num_labels_q, num_labels_d;
    logic               overflow_q, overflow_d;
    logic               new_frame_q, new_frame_d;
    logic [LABEL_W-1:0] q_q, q_d;
    logic               q_valid_q, q_valid_d;
    logic [LABEL_W-1:0] lut_data_q, lut_data_d;
    logic [LABEL_W-1:0] um_q, um_d;
    logic [LABEL_W-1:0] ur_q, ur_d;
    logic [LABEL_W-1:0] rx_q, rx_d;
    logic [LABEL_W-1:0] flat_i_q, flat_i_d;
    logic               flat_ph_q, flat_ph_d;
    logic [LABEL_W-1:0] flat_t_q, flat_t_d;

    logic [LABEL_W-1:0] lbl_tbl_q [0:MAXL];

    logic               accept;
    logic               alloc_we;
    logic [LABEL_W-1:0] alloc_lbl;
    logic               link_we, flat_we, tbl_we;
    logic [LABEL_W-1:0] link_addr, link_dat, flat_addr, flat_dat, tbl_waddr, tbl_wdata;
    logic               push0_vld, push1_vld;
    merge_t             push0_dat, push1_dat;
    logic               fifo_rd_vld, fifo_pop;
    logic [2*LABEL_W-1:0] fifo_rd_raw;
    merge_t             fifo_rd_dat;
    logic [FCW-1:0]     fifo_free;

    assign in_ready = (frame_st_q == F_RUN) && (fifo_free >= FCW'(2));
    assign accept   = in_valid && in_ready;

    // Pixel path: neighbour min, distinct-merge selection, label allocation.
    always_comb begin
        logic [LABEL_W-1:0] nb [4];
        logic [LABEL_W-1:0] m_lbl;
        logic [LABEL_W-1:0] cur_n;
        logic [3:0]         cand;

        nb[0] = (CONN8 != 0) ? A : '0;
        nb[1] = B;
        nb[2] = (CONN8 != 0) ? C : '0;
        nb[3] = D;

        m_lbl = '0;
        for (int i = 0; i < 4; i++) begin
            if (nb[i] != '0 && (m_lbl == '0 || nb[i] < m_lbl)) m_lbl = nb[i];
        end

        cand = '0;
        for (int i = 0; i < 4; i++) begin
            cand[i] = (nb[i] != '0) && (nb[i] != m_lbl);
            for (int j = 0; j < i; j++) begin
                if (cand[j] && nb[j] == nb[i]) cand[i] = 1'b0;
            end
        end

        push0_vld = 1'b0;
        push0_dat = '0;
        push1_vld = 1'b0;
        push1_dat = '0;
        for (int i = 0; i < 4; i++) begin
            if (cand[i]) begin
                if (!push0_vld) begin
                    push0_vld   = 1'b1;
                    push0_dat.x = nb[i];
                    push0_dat.m = m_lbl;
                end else if (!push1_vld) begin
                    push1_vld   = 1'b1;
                    push1_dat.x = nb[i];
                    push1_dat.m = m_lbl;
                end
            end
        end
        if (!(accept && p)) begin
            push0_vld = 1'b0;
            push1_vld = 1'b0;
        end

        // A new frame restarts the label counter before this pixel allocates.
        cur_n        = new_frame_q ? ONE_L : num_labels_q;
        num_labels_d = num_labels_q;
        overflow_d   = overflow_q;
        q_d          = q_q;
        q_valid_d    = 1'b0;
        alloc_we     = 1'b0;
        alloc_lbl    = cur_n;
        if (accept) begin
            q_valid_d    = 1'b1;
            num_labels_d = cur_n;
            overflow_d   = new_frame_q ? 1'b0 : overflow_q;
            if (!p) begin
                q_d = '0;
            end else if (m_lbl == '0) begin
                alloc_we = 1'b1;
                q_d      = cur_n;
                if (cur_n == MAXL_L) overflow_d = 1'b1;
                else                 num_labels_d = cur_n + ONE_L;
            end else begin
                q_d = m_lbl;
            end
        end
    end

    // Frame sequencing and single-pass flatten.
    always_comb begin
        frame_st_d  = frame_st_q;
        new_frame_d = new_frame_q;
        flat_i_d    = flat_i_q;
        flat_ph_d   = flat_ph_q;
        flat_t_d    = flat_t_q;
        flat_we     = 1'b0;
        flat_addr   = flat_i_q;
        flat_dat    = lbl_tbl_q[flat_t_q];
        if (accept) new_frame_d = 1'b0;
        case (frame_st_q)
            F_RUN: begin
                if (accept && in_last) frame_st_d = F_DRAIN;
            end
            F_DRAIN: begin
                if (!fifo_rd_vld && union_st_q == U_IDLE) begin
                    frame_st_d = F_FLATTEN;
                    flat_i_d   = ONE_L;
                    flat_ph_d  = 1'b0;
                end
            end
            F_FLATTEN: begin
                if (flat_i_q >= num_labels_q) begin
                    frame_st_d = F_DONE;
                end else if (!flat_ph_q) begin
                    flat_t_d  = lbl_tbl_q[flat_i_q];
                    flat_ph_d = 1'b1;
                end else begin
                    flat_we   = 1'b1;
                    flat_i_d  = flat_i_q + ONE_L;
                    flat_ph_d = 1'b0;
                end
            end
            F_DONE: begin
                frame_st_d  = F_RUN;
                new_frame_d = 1'b1;
            end
            default: frame_st_d = F_RUN;
        endcase
    end

    assign fifo_rd_dat = merge_t'(fifo_rd_raw);

    // Union-find: walk both labels to their roots, then hang the larger root under the smaller.
    always_comb begin
        union_st_d = union_st_q;
        um_d       = um_q;
        ur_d       = ur_q;
        rx_d       = rx_q;
        fifo_pop   = 1'b0;
        link_we    = 1'b0;
        link_addr  = (rx_q > ur_q) ? rx_q : ur_q;
        link_dat   = (rx_q > ur_q) ? ur_q : rx_q;
        case (union_st_q)
            U_IDLE: begin
                if (fifo_rd_vld) begin
                    fifo_pop   = 1'b1;
                    ur_d       = fifo_rd_dat.x;
                    um_d       = fifo_rd_dat.m;
                    union_st_d = U_FIND_X;
                end
            end
            U_FIND_X: begin
                if (lbl_tbl_q[ur_q] == ur_q) begin
                    rx_d       = ur_q;
                    ur_d       = um_q;
                    union_st_d = U_FIND_M;
                end else begin
                    ur_d = lbl_tbl_q[ur_q];
                end
            end
            U_FIND_M: begin
                if (lbl_tbl_q[ur_q] == ur_q) union_st_d = U_LINK;
                else                         ur_d = lbl_tbl_q[ur_q];
            end
            U_LINK: begin
                if (rx_q == ur_q) begin
                    union_st_d = U_IDLE;
                end else if (!alloc_we) begin
                    link_we    = 1'b1;
                    union_st_d = U_IDLE;
                end
            end
            default: union_st_d = U_IDLE;
        endcase
    end

    // One table write port: allocation wins, a colliding link retries next cycle.
    always_comb begin
        tbl_we    = 1'b0;
        tbl_waddr = '0;
        tbl_wdata = '0;
        if (alloc_we) begin
            tbl_we    = 1'b1;
            tbl_waddr = alloc_lbl;
            tbl_wdata = alloc_lbl;
        end else if (link_we) begin
            tbl_we    = 1'b1;
            tbl_waddr = link_addr;
            tbl_wdata = link_dat;
        end else if (flat_we) begin
            tbl_we    = 1'b1;
            tbl_waddr = flat_addr;
            tbl_wdata = flat_dat;
        end
        lut_data_d = (lut_addr >= num_labels_q) ? lut_addr : lbl_tbl_q[lut_addr];
    end

    always_ff @(posedge clk) begin
        if (tbl_we) lbl_tbl_q[tbl_waddr] <= tbl_wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_st_q   <= F_RUN;
            union_st_q   <= U_IDLE;
            num_labels_q <= ONE_L;
            overflow_q   <= 1'b0;
            new_frame_q  <= 1'b0;
            q_q          <= '0;
            q_valid_q    <= 1'b0;
            lut_data_q   <= '0;
            um_q         <= '0;
            ur_q         <= '0;
            rx_q         <= '0;
            flat_i_q     <= '0;
            flat_ph_q    <= 1'b0;
            flat_t_q     <= '0;
        end else begin
            frame_st_q   <= frame_st_d;
            union_st_q   <= union_st_d;
            num_labels_q <= num_labels_d;
            overflow_q   <= overflow_d;
            new_frame_q  <= new_frame_d;
            q_q          <= q_d;
            q_valid_q    <= q_valid_d;
            lut_data_q   <= lut_data_d;
            um_q         <= um_d;
            ur_q         <= ur_d;
            rx_q         <= rx_d;
            flat_i_q     <= flat_i_d;
            flat_ph_q    <= flat_ph_d;
            flat_t_q     <= flat_t_d;
        end
    end

    ccl_fifo #(
        .WIDTH (2*LABEL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_merge_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr0_vld  (push0_vld),
        .wr0_dat  (push0_dat),
        .wr1_vld  (push1_vld),
        .wr1_dat  (push1_dat),
        .rd_vld   (fifo_rd_vld),
        .rd_rdy   (fifo_pop),
        .rd_dat   (fifo_rd_raw),
        .free_cnt (fifo_free)
    );

    assign q           = q_q;
    assign q_valid     = q_valid_q;
    assign frame_done  = (frame_st_q == F_DONE);
    assign label_count = num_labels_q;
    assign overflow    = overflow_q;
    assign lut_data    = lut_data_q;
endmodule

// File: tb/tb_ccl_union_labeler.sv
// Bench for ccl_union_labeler: 8-bit/16-deep/8-conn instance plus 3-bit/4-deep/4-conn instance.
// Stimulus tasks queue expected q; per-instance monitors pop and compare on q_valid.
module tb_ccl_union_labeler;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic       v1, r1, l1, p1, qv1, fd1, ov1;
    logic [7:0] a1, b1, c1, d1, q1, lc1, la1, ld1;
    logic       v2, r2, l2, p2, qv2, fd2, ov2;
    logic [2:0] a2, b2, c2, d2, q2, lc2, la2, ld2;

    int total = 0;
    int bad = 0;
    int fd1_cnt = 0;
    int fd2_cnt = 0;
    bit drop2 = 1'b0;
    logic [7:0] exp1 [$];
    logic [2:0] exp2 [$];

    ccl_union_labeler #(.LABEL_W(8), .FIFO_DEPTH(16), .CONN8(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(v1), .in_ready(r1), .in_last(l1), .p(p1),
        .A(a1), .B(b1), .C(c1), .D(d1), .q(q1), .q_valid(qv1), .frame_done(fd1),
        .label_count(lc1), .overflow(ov1), .lut_addr(la1), .lut_data(ld1));

    ccl_union_labeler #(.LABEL_W(3), .FIFO_DEPTH(4), .CONN8(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(v2), .in_ready(r2), .in_last(l2), .p(p2),
        .A(a2), .B(b2), .C(c2), .D(d2), .q(q2), .q_valid(qv2), .frame_done(fd2),
        .label_count(lc2), .overflow(ov2), .lut_addr(la2), .lut_data(ld2));

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (qv1) begin
            if (exp1.size() == 0) begin
                total++; bad++;
                $display("FAIL q1_unexpected: got %0d required no output", q1);
            end else chk("q1", int'(q1), int'(exp1.pop_front()));
        end
        if (qv2) begin
            if (exp2.size() == 0) begin
                total++; bad++;
                $display("FAIL q2_unexpected: got %0d required no output", q2);
            end else chk("q2", int'(q2), int'(exp2.pop_front()));
        end
        if (fd1) fd1_cnt++;
        if (fd2) fd2_cnt++;
    end

    // Present one pixel at a negedge, hold until accepted, queue its expected label.
    task automatic px(input bit s, input bit p, input int a, input int b, input int c,
                      input int d, input bit last, input int expq);
        int n;
        bit rdy;
        n = 0;
        if (!s) begin
            v1 = 1'b1; p1 = p; a1 = 8'(a); b1 = 8'(b); c1 = 8'(c); d1 = 8'(d); l1 = last;
        end else begin
            v2 = 1'b1; p2 = p; a2 = 3'(a); b2 = 3'(b); c2 = 3'(c); d2 = 3'(d); l2 = last;
        end
        forever begin
            rdy = s ? r2 : r1;
            if (rdy) begin
                @(posedge clk);
                if (!s) exp1.push_back(8'(expq));
                else    exp2.push_back(3'(expq));
                @(negedge clk);
                break;
            end
            if (s) drop2 = 1'b1;
            @(negedge clk);
            n++;
            if (n > 500) begin
                total++; bad++;
                $display("FAIL accept_timeout: got in_ready=0 required accept within 500 cycles");
                break;
            end
        end
        if (!s) v1 = 1'b0;
        else    v2 = 1'b0;
    endtask

    task automatic wait_done(input bit s);
        int n;
        n = 0;
        while (!(s ? fd2 : fd1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++; bad++;
            $display("FAIL frame_done_timeout: got no pulse required pulse within 3000 cycles");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic lut(input bit s, input int addr, input int req);
        if (!s) la1 = 8'(addr);
        else    la2 = 3'(addr);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("lut%0d[%0d]", int'(s) + 1, addr), s ? int'(ld2) : int'(ld1), req);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got hang required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        v1 = 0; l1 = 0; p1 = 0; a1 = 0; b1 = 0; c1 = 0; d1 = 0; la1 = 0;
        v2 = 0; l2 = 0; p2 = 0; a2 = 0; b2 = 0; c2 = 0; d2 = 0; la2 = 0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_q_valid", int'(qv1), 0);
        chk("rst_q", int'(q1), 0);
        chk("rst_in_ready", int'(r1), 1);
        chk("rst_label_count", int'(lc1), 1);
        chk("rst_overflow", int'(ov1), 0);
        chk("rst_lut_data", int'(ld1), 0);
        chk("rst_frame_done", int'(fd1), 0);
        chk("rst_in_ready2", int'(r2), 1);

        // three isolated pixels
        px(0, 1, 0, 0, 0, 0, 0, 1);
        px(0, 1, 0, 0, 0, 0, 0, 2);
        px(0, 1, 0, 0, 0, 0, 1, 3);
        wait_done(0);
        chk("t1_label_count", int'(lc1), 4);
        repeat (3) @(negedge clk);
        chk("t1_done_pulses", fd1_cnt, 1);

        // B=3, D=5 merge, plus a background pixel with nonzero neighbours
        for (int i = 1; i <= 5; i++) px(0, 1, 0, 0, 0, 0, 0, i);
        px(0, 0, 4, 3, 2, 5, 0, 0);
        px(0, 1, 0, 3, 0, 5, 1, 3);
        wait_done(0);
        chk("t2_label_count", int'(lc1), 6);
        lut(0, 5, 3);
        lut(0, 3, 3);
        lut(0, 4, 4);

        // chained merges (4,2) then (2,1)
        for (int i = 1; i <= 4; i++) px(0, 1, 0, 0, 0, 0, 0, i);
        px(0, 1, 0, 4, 0, 2, 0, 2);
        px(0, 1, 0, 2, 0, 1, 1, 1);
        wait_done(0);
        chk("t3_label_count", int'(lc1), 5);
        lut(0, 4, 1);
        lut(0, 2, 1);
        lut(0, 3, 3);
        lut(0, 1, 1);
        lut(0, 200, 200);

        // 8-connectivity: A=2, C=7, D=4 -> two merges
        for (int i = 1; i <= 7; i++) px(0, 1, 0, 0, 0, 0, 0, i);
        px(0, 1, 2, 0, 7, 4, 1, 2);
        wait_done(0);
        lut(0, 7, 2);
        lut(0, 4, 2);
        lut(0, 2, 2);
        lut(0, 5, 5);
        chk("t4_done_pulses", fd1_cnt, 4);

        // label saturation on the 3-bit instance
        for (int i = 1; i <= 8; i++) px(1, 1, 0, 0, 0, 0, (i == 8), (i < 8) ? i : 7);
        wait_done(1);
        chk("t5_overflow", int'(ov2), 1);
        chk("t5_label_count", int'(lc2), 7);

        // back-to-back merges into a 4-deep FIFO
        drop2 = 1'b0;
        px(1, 1, 0, 0, 0, 0, 0, 1);
        chk("t5_overflow_clear", int'(ov2), 0);
        for (int i = 2; i <= 6; i++) px(1, 1, 0, 0, 0, 0, 0, i);
        px(1, 1, 0, 2, 0, 1, 0, 1);
        px(1, 1, 0, 4, 0, 3, 0, 3);
        px(1, 1, 0, 6, 0, 5, 0, 5);
        px(1, 1, 0, 3, 0, 1, 0, 1);
        px(1, 1, 0, 5, 0, 1, 1, 1);
        wait_done(1);
        chk("t6_ready_dropped", int'(drop2), 1);
        chk("t6_label_count", int'(lc2), 7);
        for (int i = 1; i <= 6; i++) lut(1, i, 1);
        lut(1, 7, 7);

        // 4-connectivity ignores A and C; then reset during flatten
        px(1, 1, 2, 0, 7, 0, 0, 1);
        px(1, 1, 0, 0, 0, 0, 0, 2);
        px(1, 1, 0, 0, 0, 0, 1, 3);
        repeat (3) @(negedge clk);
        chk("t6_busy_before_reset", int'(r2), 0);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk("t6_rst_in_ready", int'(r2), 1);
        chk("t6_rst_label_count", int'(lc2), 1);
        chk("t6_rst_q_valid", int'(qv2), 0);
        repeat (20) @(negedge clk);
        chk("t6_no_done_after_reset", fd2_cnt, 2);
        chk("sb1_drained", exp1.size(), 0);
        chk("sb2_drained", exp2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
